// File: rtl/fwd_stall_ctrl.sv
// Hazard resolution for the RV32I 5-stage pipe: EX operand forwarding selects,
// load-use stall, branch flush and external freeze. Macro HAZARD_PERF_EN adds perf counters.

`ifndef FROM_EX_RS1
`define FROM_EX_RS1 3'b001
`endif
`ifndef FROM_EX_RS2
`define FROM_EX_RS2 3'b010
`endif
`ifndef FROM_MEM_RS1
`define FROM_MEM_RS1 3'b011
`endif
`ifndef FROM_MEM_RS2
`define FROM_MEM_RS2 3'b100
`endif

module fwd_stall_ctrl #(
  parameter int unsigned FLUSH_CYCLES = 1
`ifdef HAZARD_PERF_EN
  , parameter int unsigned CNT_W = 32
`endif
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       id_valid,
  input  logic [3:0] hazard_ex,
  input  logic [3:0] hazard_mem,
  input  logic       ex_is_load,
  input  logic       branch_taken,
  input  logic       stall_ext,
  output logic [1:0] fwd_rs1_sel,
  output logic [1:0] fwd_rs2_sel,
  output logic       pc_stall,
  output logic       ifid_stall,
  output logic       idex_bubble,
  output logic       ifid_flush,
  output logic       ex_hold
`ifdef HAZARD_PERF_EN
  , output logic [CNT_W-1:0] perf_stall_cnt
  , output logic [CNT_W-1:0] perf_flush_cnt
`endif
);

  localparam int unsigned CW = 3;
  localparam logic [2:0] C_EX_RS1  = `FROM_EX_RS1;
  localparam logic [2:0] C_EX_RS2  = `FROM_EX_RS2;
  localparam logic [2:0] C_MEM_RS1 = `FROM_MEM_RS1;
  localparam logic [2:0] C_MEM_RS2 = `FROM_MEM_RS2;
  localparam logic [1:0] SEL_RF  = 2'b00;
  localparam logic [1:0] SEL_EX  = 2'b01;
  localparam logic [1:0] SEL_MEM = 2'b10;

  typedef enum logic [1:0] {ST_RUN, ST_LU_STALL, ST_FLUSH} state_t;

  state_t        r_state, w_state_nxt;
  logic [CW-1:0] r_cnt, w_cnt_nxt;
  logic [1:0]    r_rs1_sel, r_rs2_sel, w_rs1_nxt, w_rs2_nxt, w_rs1_fwd, w_rs2_fwd;
  logic          w_pc_stall, w_ifid_stall, w_idex_bubble, w_ifid_flush, w_ex_hold;
  logic          w_lu_bubble, w_load_use, w_ex_ok;
  logic          w_ex_rs1, w_ex_rs2, w_mem_rs1, w_mem_rs2;

  // EX-side hazards only count in RUN; in LU_STALL the EX slot holds the bubble
  assign w_ex_ok    = (r_state == ST_RUN);
  assign w_ex_rs1   = hazard_ex[3]  && (hazard_ex[2:0]  == C_EX_RS1);
  assign w_ex_rs2   = hazard_ex[3]  && (hazard_ex[2:0]  == C_EX_RS2);
  assign w_mem_rs1  = hazard_mem[3] && (hazard_mem[2:0] == C_MEM_RS1);
  assign w_mem_rs2  = hazard_mem[3] && (hazard_mem[2:0] == C_MEM_RS2);
  assign w_load_use = id_valid && hazard_ex[3] && ex_is_load;

  always_comb begin
    w_rs1_fwd = SEL_RF;
    w_rs2_fwd = SEL_RF;
    if (id_valid) begin
      if (w_ex_ok && w_ex_rs1) w_rs1_fwd = SEL_EX;
      else if (w_mem_rs1)      w_rs1_fwd = SEL_MEM;
      if (w_ex_ok && w_ex_rs2) w_rs2_fwd = SEL_EX;
      else if (w_mem_rs2)      w_rs2_fwd = SEL_MEM;
    end
  end

  // Next state / control outputs, priority stall_ext > branch > load-use > forwarding
  always_comb begin
    w_state_nxt   = r_state;
    w_cnt_nxt     = r_cnt;
    w_rs1_nxt     = r_rs1_sel;
    w_rs2_nxt     = r_rs2_sel;
    w_pc_stall    = 1'b0;
    w_ifid_stall  = 1'b0;
    w_idex_bubble = 1'b0;
    w_ifid_flush  = 1'b0;
    w_ex_hold     = 1'b0;
    w_lu_bubble   = 1'b0;
    if (stall_ext) begin
      w_pc_stall   = 1'b1;
      w_ifid_stall = 1'b1;
      w_ex_hold    = 1'b1;
    end else if (branch_taken) begin
      w_ifid_flush  = 1'b1;
      w_idex_bubble = 1'b1;
      w_rs1_nxt     = SEL_RF;
      w_rs2_nxt     = SEL_RF;
      if (FLUSH_CYCLES <= 1) begin
        w_state_nxt = ST_RUN;
        w_cnt_nxt   = '0;
      end else begin
        w_state_nxt = ST_FLUSH;
        w_cnt_nxt   = CW'(FLUSH_CYCLES - 1);
      end
    end else begin
      case (r_state)
        ST_FLUSH: begin
          w_ifid_flush  = 1'b1;
          w_idex_bubble = 1'b1;
          w_rs1_nxt     = SEL_RF;
          w_rs2_nxt     = SEL_RF;
          w_cnt_nxt     = r_cnt - CW'(1);
          if (r_cnt <= CW'(1)) begin
            w_state_nxt = ST_RUN;
            w_cnt_nxt   = '0;
          end
        end
        ST_LU_STALL: begin
          w_state_nxt = ST_RUN;
          w_rs1_nxt   = w_rs1_fwd;
          w_rs2_nxt   = w_rs2_fwd;
        end
        default: begin
          if (w_load_use) begin
            w_pc_stall    = 1'b1;
            w_ifid_stall  = 1'b1;
            w_idex_bubble = 1'b1;
            w_lu_bubble   = 1'b1;
            w_state_nxt   = ST_LU_STALL;
            w_rs1_nxt     = SEL_RF;
            w_rs2_nxt     = SEL_RF;
          end else begin
            w_rs1_nxt = w_rs1_fwd;
            w_rs2_nxt = w_rs2_fwd;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ST_RUN;
      r_cnt     <= '0;
      r_rs1_sel <= SEL_RF;
      r_rs2_sel <= SEL_RF;
    end else begin
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      r_rs1_sel <= w_rs1_nxt;
      r_rs2_sel <= w_rs2_nxt;
    end
  end

  // Control strobes act in the current cycle; reset must silence them immediately
  assign fwd_rs1_sel = r_rs1_sel;
  assign fwd_rs2_sel = r_rs2_sel;
  assign pc_stall    = rst_n & w_pc_stall;
  assign ifid_stall  = rst_n & w_ifid_stall;
  assign idex_bubble = rst_n & w_idex_bubble;
  assign ifid_flush  = rst_n & w_ifid_flush;
  assign ex_hold     = rst_n & w_ex_hold;

`ifdef HAZARD_PERF_EN
  logic [CNT_W-1:0] r_perf_stall, r_perf_flush;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_perf_stall <= '0;
      r_perf_flush <= '0;
    end else begin
      if (w_lu_bubble && (r_perf_stall != '1))  r_perf_stall <= r_perf_stall + CNT_W'(1);
      if (w_ifid_flush && (r_perf_flush != '1)) r_perf_flush <= r_perf_flush + CNT_W'(1);
    end
  end

  assign perf_stall_cnt = r_perf_stall;
  assign perf_flush_cnt = r_perf_flush;
`endif

endmodule

// File: doc/fwd_stall_ctrl.md
Name: fwd_stall_ctrl

Overview:
- Pipeline control block between the two hazard_detection instances (ID-vs-EX and ID-vs-MEM) and the ID/EX pipeline register.
- Consumes their 4-bit hazard codes; produces registered EX-stage operand forwarding selects, load-use stall/bubble, branch flush, and external-stall freeze.
- Small FSM plus flush counter; RV32I 5-stage core.

Parameters:
FLUSH_CYCLES, 1, cycles IF/ID is flushed per taken branch (1..7)
CNT_W, 32, perf counter width (optional feature only)

Ports:
clk  in  1  core clock
rst_n  in  1  reset, asynchronous, active-low
id_valid  in  1  ID holds a valid instruction
hazard_ex  in  4  ID-vs-EX hazard code: bit3 valid, bits2:0 = `FROM_EX_RS1/`FROM_EX_RS2
hazard_mem  in  4  ID-vs-MEM hazard code: bit3 valid, bits2:0 = `FROM_MEM_RS1/`FROM_MEM_RS2
ex_is_load  in  1  instruction in EX is a LOAD
branch_taken  in  1  EX resolved taken branch/jump, 1-cycle pulse
stall_ext  in  1  memory-side stall, freezes whole pipe
fwd_rs1_sel  out  2  EX rs1 source: 00 regfile, 01 EX/MEM, 10 MEM/WB
fwd_rs2_sel  out  2  EX rs2 source, same encoding
pc_stall  out  1  hold PC
ifid_stall  out  1  hold IF/ID
idex_bubble  out  1  load NOP into ID/EX
ifid_flush  out  1  clear IF/ID to NOP
ex_hold  out  1  hold ID/EX, EX/MEM, MEM/WB

Behaviour:
- Reset (async, rst_n=0): state RUN, flush counter 0, fwd_rs1_sel/fwd_rs2_sel 00; all stall/flush outputs 0. Reset mid-stall or mid-flush aborts immediately.
- States: RUN, LU_STALL, FLUSH.
- Priority in any state: stall_ext > branch_taken > load-use > forwarding.
- stall_ext=1:
  - pc_stall=ifid_stall=ex_hold=1; idex_bubble=ifid_flush=0.
  - State, counter and fwd selects hold.
  - A branch_taken pulse coinciding with stall_ext is held by EX and must be re-presented; this block does not latch it.
- branch_taken=1 (stall_ext=0), any state:
  - ifid_flush=1, idex_bubble=1 this cycle.
  - FLUSH_CYCLES=1: next state RUN.
  - Otherwise next state FLUSH with counter=FLUSH_CYCLES-1.
  - Any pending load-use is discarded.
- FLUSH:
  - ifid_flush=1, idex_bubble=1; counter decrements.
  - Counter==1: next state RUN.
  - Hazard inputs ignored.
- Load-use, RUN only: id_valid && hazard_ex[3] && ex_is_load.
  - Same cycle: pc_stall=ifid_stall=idex_bubble=1.
  - Next state LU_STALL.
  - Registered fwd selects load 00, since the bubble enters EX.
- LU_STALL (exactly 1 cycle):
  - No stall outputs.
  - hazard_ex ignored (EX holds the bubble); hazard_mem processed normally, so the load value forwards via 10.
  - Next state RUN.
- Forwarding in RUN/LU_STALL without stall:
  - Per operand, sel_next = 01 if hazard_ex[3] and code names that operand (RUN only); else 10 if hazard_mem[3] and code names that operand; else 00.
  - EX source has priority over MEM.
  - Registered on clk rising edge, so selects are valid in the cycle the instruction occupies EX (1-cycle latency).
  - id_valid=0 or idex_bubble=1: selects register 00.
- ifid_flush and pc_stall never both 1, except under stall_ext (flush forced 0).

Optional Feature:
- Macro: HAZARD_PERF_EN.
- Defined:
  - Adds outputs perf_stall_cnt and perf_flush_cnt (CNT_W each), both reset to 0.
  - perf_stall_cnt increments each cycle idex_bubble=1 from load-use.
  - perf_flush_cnt increments each cycle ifid_flush=1.
  - Both saturate at all-ones and hold under stall_ext.
- Undefined: ports and logic absent; remaining behaviour identical.

Test Plan:
- Reset: drive rst_n=0 mid-FLUSH (FLUSH_CYCLES=3) -> all outputs 0 asynchronously; after release, state RUN, sels 00.
- ALU->ALU: hazard_ex=1_`FROM_EX_RS1, ex_is_load=0 -> no stall; next cycle fwd_rs1_sel=01, fwd_rs2_sel=00.
- Load-use: hazard_ex=1_`FROM_EX_RS2, ex_is_load=1 -> pc_stall/ifid_stall/idex_bubble=1 one cycle, sels 00; then hazard_mem=1_`FROM_MEM_RS2 -> next cycle fwd_rs2_sel=10, no further stall.
- Dual source: hazard_ex=1_`FROM_EX_RS1 and hazard_mem=1_`FROM_MEM_RS1 -> fwd_rs1_sel=01 (EX wins).
- Branch during load-use: branch_taken=1 with load-use condition, FLUSH_CYCLES=2 -> ifid_flush=idex_bubble=1 for 2 cycles, pc_stall=0, return to RUN.
- stall_ext=1 for 3 cycles in LU_STALL -> ex_hold=1, state and sels frozen; with HAZARD_PERF_EN, counters unchanged; resumes LU_STALL behaviour after release.
